// File: rtl/conv_pkg.sv
// Shared types, defaults and width helper for the convolution tap sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } conv_state_e;

  localparam int DEF_SIZE  = 32;
  localparam int DEF_KSIZE = 32;

  // Never returns 0, so a one-entry range still gets a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Tap command channel from the sequencer to the memory/MAC, plus the per-pixel result ack.
interface conv_sequencer_if #(
  parameter int PW = conv_pkg::clog2_min1(conv_pkg::DEF_SIZE * conv_pkg::DEF_SIZE),
  parameter int KW = conv_pkg::clog2_min1(conv_pkg::DEF_KSIZE * conv_pkg::DEF_KSIZE)
) ();

  logic          tap_valid;
  logic          tap_ready;
  logic [KW-1:0] tap_kaddr;
  logic [PW-1:0] tap_waddr;
  logic [PW-1:0] tap_pix;
  logic          tap_first;
  logic          tap_last;
  logic          res_ack;

  modport master (
    output tap_valid, tap_kaddr, tap_waddr, tap_pix, tap_first, tap_last,
    input  tap_ready, res_ack
  );

  modport slave (
    input  tap_valid, tap_kaddr, tap_waddr, tap_pix, tap_first, tap_last,
    output tap_ready, res_ack
  );

endinterface

// File: rtl/conv_idx2d.sv
// Row-major 2D index counter with runtime limits; exposes the index it will hold after
// the coming edge and a flag marking the last position of the sweep.
module conv_idx2d #(
  parameter int RW = 2,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [RW-1:0] row_hi,
  input  logic [CW-1:0] col_hi,
  output logic [RW-1:0] row_nxt,
  output logic [CW-1:0] col_nxt,
  output logic          wrap
);

  logic [RW-1:0] row_r;
  logic [CW-1:0] col_r;

  assign wrap = (row_r == row_hi) && (col_r == col_hi);

  // Next index: clear wins, otherwise step the column and carry into the row
  always_comb begin
    row_nxt = row_r;
    col_nxt = col_r;
    if (clr) begin
      row_nxt = {RW{1'b0}};
      col_nxt = {CW{1'b0}};
    end else if (en) begin
      if (col_r == col_hi) begin
        col_nxt = {CW{1'b0}};
        if (row_r == row_hi) begin
          row_nxt = {RW{1'b0}};
        end else begin
          row_nxt = row_r + RW'(1);
        end
      end else begin
        col_nxt = col_r + CW'(1);
      end
    end else begin
      row_nxt = row_r;
      col_nxt = col_r;
    end
  end

  // Index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_r <= {RW{1'b0}};
      col_r <= {CW{1'b0}};
    end else begin
      row_r <= row_nxt;
      col_r <= col_nxt;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Sweeps every output pixel of a SIZE x SIZE world and issues the kernel taps that land
// on it, tracking pixels whose results are still outstanding at the MAC.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int KSIZE = DEF_KSIZE,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  conv_sequencer_if.master tap,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PW  = clog2_min1(SIZE * SIZE);
  localparam int KW  = clog2_min1(KSIZE * KSIZE);
  localparam int OW  = clog2_min1(SIZE * SIZE + 1);
  localparam int IW  = clog2_min1(SIZE);
  localparam int KIW = clog2_min1(KSIZE);
  localparam int H   = KSIZE / 2;

  // Without wrap the in-range taps of a pixel form a rectangle, so the kernel counter
  // walks offsets from its low corner and clipped taps cost no cycles.
  function automatic int lo_of(input int c);
    return (WRAP != 0 || c >= H) ? 0 : H - c;
  endfunction

  function automatic int hi_of(input int c);
    return (WRAP != 0 || c + KSIZE - 1 - H <= SIZE - 1) ? KSIZE - 1 : SIZE - 1 - c + H;
  endfunction

  conv_state_e    state_r, state_nxt_s;
  logic           tap_valid_r, valid_nxt_s;
  logic           busy_r, done_r, err_r, err_nxt_s;
  logic [KW-1:0]  kaddr_r, kaddr_nxt_s;
  logic [PW-1:0]  waddr_r, waddr_nxt_s;
  logic [PW-1:0]  pix_r, pix_nxt_s;
  logic           first_r, first_nxt_s;
  logic           last_r, last_nxt_s;
  logic [KIW-1:0] dk_hi_r, dl_hi_r, dk_hi_nxt_s, dl_hi_nxt_s;
  logic [OW-1:0]  cnt_r, cnt_nxt_s;
  logic [IW-1:0]  i_nxt_s, j_nxt_s;
  logic [KIW-1:0] dk_nxt_s, dl_nxt_s;
  logic           ij_wrap_s, kl_wrap_s;
  logic           start_acc_s, accept_s, abort_s, final_s, load_s;
  logic           inc_s, dec_s, spurious_s;
  int             in_s, jn_s, k_s, l_s, x_raw_s, y_raw_s, x_s, y_s;

  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign accept_s    = tap_valid_r && tap.tap_ready;
  assign abort_s     = (state_r == ST_RUN) && abort;
  assign final_s     = accept_s && kl_wrap_s && ij_wrap_s;
  assign load_s      = start_acc_s || accept_s;
  assign inc_s       = accept_s && last_r;
  assign dec_s       = tap.res_ack && ((cnt_r != {OW{1'b0}}) || inc_s);
  assign spurious_s  = tap.res_ack && !inc_s && (cnt_r == {OW{1'b0}});

  conv_idx2d #(.RW(IW), .CW(IW)) u_pix_idx (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_acc_s),
    .en      (accept_s && kl_wrap_s),
    .row_hi  (IW'(SIZE - 1)),
    .col_hi  (IW'(SIZE - 1)),
    .row_nxt (i_nxt_s),
    .col_nxt (j_nxt_s),
    .wrap    (ij_wrap_s)
  );

  conv_idx2d #(.RW(KIW), .CW(KIW)) u_tap_idx (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_acc_s),
    .en      (accept_s),
    .row_hi  (dk_hi_r),
    .col_hi  (dl_hi_r),
    .row_nxt (dk_nxt_s),
    .col_nxt (dl_nxt_s),
    .wrap    (kl_wrap_s)
  );

  // Fields of the tap the counters will point at after the coming edge
  always_comb begin
    in_s        = int'(i_nxt_s);
    jn_s        = int'(j_nxt_s);
    k_s         = lo_of(in_s) + int'(dk_nxt_s);
    l_s         = lo_of(jn_s) + int'(dl_nxt_s);
    x_raw_s     = in_s + k_s - H;
    y_raw_s     = jn_s + l_s - H;
    x_s         = (WRAP != 0) ? (x_raw_s + SIZE) % SIZE : x_raw_s;
    y_s         = (WRAP != 0) ? (y_raw_s + SIZE) % SIZE : y_raw_s;
    kaddr_nxt_s = KW'(k_s * KSIZE + l_s);
    waddr_nxt_s = PW'(x_s * SIZE + y_s);
    pix_nxt_s   = PW'(in_s * SIZE + jn_s);
    dk_hi_nxt_s = KIW'(hi_of(in_s) - lo_of(in_s));
    dl_hi_nxt_s = KIW'(hi_of(jn_s) - lo_of(jn_s));
    first_nxt_s = (dk_nxt_s == {KIW{1'b0}}) && (dl_nxt_s == {KIW{1'b0}});
    last_nxt_s  = (dk_nxt_s == dk_hi_nxt_s) && (dl_nxt_s == dl_hi_nxt_s);
  end

  // Outstanding-result count and sticky error
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_nxt_s = err_r;
    if (start_acc_s) begin
      cnt_nxt_s = {OW{1'b0}};
      err_nxt_s = 1'b0;
    end else begin
      case ({inc_s, dec_s})
        2'b10:   cnt_nxt_s = cnt_r + OW'(1);
        2'b01:   cnt_nxt_s = cnt_r - OW'(1);
        default: cnt_nxt_s = cnt_r;
      endcase
      if (abort_s || spurious_s) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end
  end

  // Next state and next tap_valid
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort || final_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_nxt_s == {OW{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered tap command, status outputs and per-pixel kernel limits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= {OW{1'b0}};
      kaddr_r     <= {KW{1'b0}};
      waddr_r     <= {PW{1'b0}};
      pix_r       <= {PW{1'b0}};
      first_r     <= 1'b0;
      last_r      <= 1'b0;
      dk_hi_r     <= {KIW{1'b0}};
      dl_hi_r     <= {KIW{1'b0}};
    end else begin
      tap_valid_r <= valid_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_nxt_s == ST_DONE);
      err_r       <= err_nxt_s;
      cnt_r       <= cnt_nxt_s;
      if (load_s) begin
        kaddr_r <= kaddr_nxt_s;
        waddr_r <= waddr_nxt_s;
        pix_r   <= pix_nxt_s;
        first_r <= first_nxt_s;
        last_r  <= last_nxt_s;
        dk_hi_r <= dk_hi_nxt_s;
        dl_hi_r <= dl_hi_nxt_s;
      end
    end
  end

  assign tap.tap_valid = tap_valid_r;
  assign tap.tap_kaddr = kaddr_r;
  assign tap.tap_waddr = waddr_r;
  assign tap.tap_pix   = pix_r;
  assign tap.tap_first = first_r;
  assign tap.tap_last  = last_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer at SIZE=4, KSIZE=3, one instance per wrap mode.
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int SIZE  = 4;
  localparam int KSIZE = 3;
  localparam int PW    = clog2_min1(SIZE * SIZE);
  localparam int KW    = clog2_min1(KSIZE * KSIZE);
  localparam int TW    = KW + 2 * PW + 2;

  logic clk = 1'b0;
  logic reset, start, abort, ready, ack, sel;
  logic busy0, done0, err0, busy1, done1, err1;
  logic obs_valid, obs_busy, obs_done, obs_err;
  logic [TW-1:0] obs_tap, tap0, tap1;
  logic [TW-1:0] exp_tap[$];
  int n_assert = 0;
  int n_fail   = 0;

  conv_sequencer_if #(.PW(PW), .KW(KW)) if0 ();
  conv_sequencer_if #(.PW(PW), .KW(KW)) if1 ();

  assign if0.tap_ready = ready & ~sel;
  assign if0.res_ack   = ack & ~sel;
  assign if1.tap_ready = ready & sel;
  assign if1.res_ack   = ack & sel;

  conv_sequencer #(.SIZE(SIZE), .KSIZE(KSIZE), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start & ~sel), .abort(abort & ~sel),
    .tap(if0), .busy(busy0), .done(done0), .err(err0)
  );

  conv_sequencer #(.SIZE(SIZE), .KSIZE(KSIZE), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start & sel), .abort(abort & sel),
    .tap(if1), .busy(busy1), .done(done1), .err(err1)
  );

  assign tap0      = {if0.tap_kaddr, if0.tap_waddr, if0.tap_pix, if0.tap_first, if0.tap_last};
  assign tap1      = {if1.tap_kaddr, if1.tap_waddr, if1.tap_pix, if1.tap_first, if1.tap_last};
  assign obs_tap   = sel ? tap1 : tap0;
  assign obs_valid = sel ? if1.tap_valid : if0.tap_valid;
  assign obs_busy  = sel ? busy1 : busy0;
  assign obs_done  = sel ? done1 : done0;
  assign obs_err   = sel ? err1 : err0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference tap list: brute-force sweep over every kernel position, dropping off-world ones
  task automatic build_expected(input int wrap);
    int x, y;
    bit first;
    logic [TW-1:0] t;
    exp_tap.delete();
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        first = 1'b1;
        for (int k = 0; k < KSIZE; k++) begin
          for (int l = 0; l < KSIZE; l++) begin
            x = i + k - KSIZE / 2;
            y = j + l - KSIZE / 2;
            if (wrap != 0) begin
              x = (x + SIZE) % SIZE;
              y = (y + SIZE) % SIZE;
            end
            if (x >= 0 && x < SIZE && y >= 0 && y < SIZE) begin
              exp_tap.push_back({KW'(k * KSIZE + l), PW'(x * SIZE + y), PW'(i * SIZE + j), first, 1'b0});
              first = 1'b0;
            end
          end
        end
        t = exp_tap.pop_back();
        t[0] = 1'b1;
        exp_tap.push_back(t);
      end
    end
  endtask

  task automatic run_pass(input logic s, input bit stall, input bit hold, input int abort_at,
                          input int exp_taps, output logic [TW-1:0] first_tap);
    int idx = 0, iter = 0, total, acks_left = 0, last_ack_iter = -100;
    bit ack_next = 1'b0, ack_q = 1'b0, aborted = 1'b0, stalled = 1'b0, done_seen = 1'b0;
    logic [TW-1:0] held = '0;
    first_tap = '0;
    build_expected(int'(s));
    total = exp_tap.size();
    sel = s; ready = 1'b0; ack = 1'b0; abort = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", obs_busy, 1);
    check("err_clear_on_start", obs_err, 0);
    while (!done_seen && iter < 3000) begin
      ack = 1'b0;
      abort = 1'b0;
      if (obs_done) begin
        done_seen = 1'b1;
        if (hold) check("done_latency", iter, last_ack_iter + 1);
      end else begin
        if (stalled) check("stall_hold", obs_tap, held);
        if (aborted) check("no_tap_after_abort", obs_valid, 0);
        else if (!stall && idx < total) check("no_bubble", obs_valid, 1);
        if (hold && idx == total) check("drain_busy", obs_busy, 1);
        if (hold) begin
          ack = (idx == total) && (acks_left > 0) && !ack_q;
          if (ack) acks_left--;
        end else begin
          ack = ack_next;
        end
        ack_q = ack;
        ack_next = 1'b0;
        if (ack) last_ack_iter = iter;
        if (abort_at >= 0 && !aborted && idx == abort_at) begin
          abort = 1'b1;
          ready = 1'b0;
          aborted = 1'b1;
        end else begin
          ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (obs_valid && ready) begin
          if (idx < total) check("tap", obs_tap, exp_tap[idx]);
          else check("tap_overrun", idx, total - 1);
          if (idx == 0) first_tap = obs_tap;
          if (obs_tap[0]) begin
            if (hold) acks_left++;
            else ack_next = 1'b1;
          end
          idx++;
        end
        stalled = obs_valid && !ready;
        held = obs_tap;
      end
      @(posedge clk); #1;
      iter++;
    end
    abort = 1'b0; ready = 1'b0; ack = 1'b0;
    check("done_seen", done_seen, 1);
    check("tap_count", idx, exp_taps);
    check("err_end", obs_err, (abort_at >= 0));
    @(posedge clk); #1;
    check("done_one_cycle", obs_done, 0);
    check("idle_after_done", obs_busy, 0);
  endtask

  initial begin
    logic [TW-1:0] ft;
    start = 1'b0; abort = 1'b0; ready = 1'b0; ack = 1'b0; sel = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid0", if0.tap_valid, 0);
    check("rst_tap0", tap0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_err0", err0, 0);
    check("rst_valid1", if1.tap_valid, 0);
    check("rst_tap1", tap1, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_pass(1'b0, 1'b0, 1'b0, -1, 100, ft);
    check("first_tap_nowrap", ft, {KW'(4), PW'(0), PW'(0), 1'b1, 1'b0});
    run_pass(1'b1, 1'b0, 1'b0, -1, 144, ft);
    check("first_tap_wrap", ft, {KW'(0), PW'(15), PW'(0), 1'b1, 1'b0});
    run_pass(1'b0, 1'b1, 1'b0, -1, 100, ft);
    check("first_tap_stall", ft, {KW'(4), PW'(0), PW'(0), 1'b1, 1'b0});
    run_pass(1'b0, 1'b0, 1'b1, -1, 100, ft);
    run_pass(1'b0, 1'b0, 1'b0, 20, 20, ft);
    run_pass(1'b0, 1'b0, 1'b0, -1, 100, ft);

    sel = 1'b0;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("spurious_err", err0, 1);
    check("spurious_idle", busy0, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_busy", busy0, 0);
    check("abort_idle_valid", if0.tap_valid, 0);

    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", if0.tap_valid, 0);
    check("midrst_tap", tap0, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_err", err0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ready = 1'b0;
    @(posedge clk); #1;
    run_pass(1'b0, 1'b0, 1'b0, -1, 100, ft);
    check("first_tap_after_rst", ft, {KW'(4), PW'(0), PW'(0), 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
